// File: rtl/rv_ctrl_pkg.sv
// Shared RV32I control encodings: opcodes, multi-cycle FSM states and datapath mux selects.
// Used by both the multi-cycle controller and the single-cycle ControlUnit.
package rv_ctrl_pkg;
  localparam int STATE_W = 4;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_LUI      = 4'd8,
    S_ALUWB    = 4'd9,
    S_BRANCH   = 4'd10,
    S_JAL      = 4'd11,
    S_JALR     = 4'd12,
    S_JLINK    = 4'd13
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD = 2'd0,
    ALUOP_SUB = 2'd1,
    ALUOP_R   = 2'd2,
    ALUOP_I   = 2'd3
  } aluop_t;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_SLL  = 4'b1010;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  function automatic logic is_known_op(input logic [6:0] opc);
    case (opc)
      OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE,
      OP_BRANCH, OP_JAL, OP_JALR, OP_LUI: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/alu_decoder.sv
// Maps the op-class chosen by the FSM plus funct3/funct7 to an ALUControl code.
// Immediate ops never decode sub; only shifts-right look at funct7.
module alu_decoder
  import rv_ctrl_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [3:0] alu_control
);
  logic alt_s;

  // funct3 decode shared by register and immediate arithmetic
  always_comb begin
    alt_s       = (funct7 == F7_ALT);
    alu_control = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_R, ALUOP_I: begin
        case (funct3)
          3'b000:  alu_control = (aluop == ALUOP_R && alt_s) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_control = ALU_SLL;
          3'b010:  alu_control = ALU_SLT;
          3'b011:  alu_control = ALU_SLTU;
          3'b100:  alu_control = ALU_XOR;
          3'b101:  alu_control = alt_s ? ALU_SRA : ALU_SRL;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end
endmodule

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multi-cycle RV32I datapath with a ready-handshaked memory port.
// Outputs are Moore decodes of state, gated only by mem_ready, the branch condition and reset.
module multicycle_controller
  import rv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUControl,
  output logic [2:0] ImmSrc,
  output logic       RegWrite,
  output logic       instr_done,
  output logic       illegal_op
);
  state_t state_r, next_s;
  aluop_t aluop_s;

  alu_decoder u_alu_decoder (
    .aluop      (aluop_s),
    .funct3     (funct3),
    .funct7     (funct7),
    .alu_control(ALUControl)
  );

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_r <= S_FETCH;
    else        state_r <= next_s;
  end

  // next-state selection
  always_comb begin
    next_s = S_FETCH;
    case (state_r)
      S_FETCH:    next_s = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: next_s = S_MEMADR;
          OP_RTYPE:          next_s = S_EXECR;
          OP_ITYPE:          next_s = S_EXECI;
          OP_BRANCH:         next_s = S_BRANCH;
          OP_JAL:            next_s = S_JAL;
          OP_JALR:           next_s = S_JALR;
          OP_LUI:            next_s = S_LUI;
          default:           next_s = S_FETCH;
        endcase
      end
      S_MEMADR:   next_s = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  next_s = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    next_s = S_FETCH;
      S_MEMWRITE: next_s = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR, S_EXECI, S_LUI: next_s = S_ALUWB;
      S_ALUWB:    next_s = S_FETCH;
      S_BRANCH:   next_s = S_FETCH;
      S_JAL, S_JALR: next_s = S_JLINK;
      S_JLINK:    next_s = S_ALUWB;
      default:    next_s = S_FETCH;
    endcase
  end

  // datapath controls; reset and unreachable encodings leave everything at zero
  always_comb begin
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RD2;
    ImmSrc     = IMM_I;
    RegWrite   = 1'b0;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    aluop_s    = ALUOP_ADD;
    if (!rst_n) begin
      aluop_s = ALUOP_ADD;
    end else begin
      case (state_r)
        S_FETCH: begin
          MemRead   = 1'b1;
          ALUSrcB   = SRCB_FOUR;
          ResultSrc = RES_ALURESULT;
          IRWrite   = mem_ready;
          PCWrite   = mem_ready;
        end
        S_DECODE: begin
          ALUSrcA    = SRCA_OLDPC;
          ALUSrcB    = SRCB_IMM;
          ImmSrc     = IMM_B;
          illegal_op = ~is_known_op(op);
          instr_done = ~is_known_op(op);
        end
        S_MEMADR: begin
          ALUSrcA = SRCA_RD1;
          ALUSrcB = SRCB_IMM;
          ImmSrc  = (op == OP_STORE) ? IMM_S : IMM_I;
        end
        S_MEMREAD: begin
          MemRead = 1'b1;
          AdrSrc  = 1'b1;
        end
        S_MEMWB: begin
          ResultSrc  = RES_DATA;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWRITE: begin
          MemWrite   = 1'b1;
          AdrSrc     = 1'b1;
          instr_done = mem_ready;
        end
        S_EXECR: begin
          ALUSrcA = SRCA_RD1;
          aluop_s = ALUOP_R;
        end
        S_EXECI: begin
          ALUSrcA = SRCA_RD1;
          ALUSrcB = SRCB_IMM;
          aluop_s = ALUOP_I;
        end
        S_LUI: begin
          ALUSrcA = SRCA_ZERO;
          ALUSrcB = SRCB_IMM;
          ImmSrc  = IMM_U;
        end
        S_ALUWB: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA    = SRCA_RD1;
          aluop_s    = ALUOP_SUB;
          PCWrite    = ((funct3 == 3'b000) && Zero) || ((funct3 == 3'b001) && !Zero);
          instr_done = 1'b1;
        end
        S_JAL: begin
          ALUSrcA = SRCA_OLDPC;
          ALUSrcB = SRCB_IMM;
          ImmSrc  = IMM_J;
        end
        S_JALR: begin
          ALUSrcA = SRCA_RD1;
          ALUSrcB = SRCB_IMM;
        end
        S_JLINK: begin
          ALUSrcA = SRCA_OLDPC;
          ALUSrcB = SRCB_FOUR;
          PCWrite = 1'b1;
        end
        default: aluop_s = ALUOP_ADD;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: the driver walks each instruction through its phases, pushing expected controls;
// a negedge monitor pops and compares every cycle and checks instruction latency on instr_done.
module tb_multicycle_controller;
  typedef struct packed {
    logic       pcw, adr, mrd, mwr, irw;
    logic [1:0] res, srca, srcb;
    logic [3:0] alu;
    logic [2:0] imm;
    logic       rw, done, ill;
  } ctl_t;

  localparam int K_R = 0, K_I = 1, K_LOAD = 2, K_STORE = 3, K_BR = 4;
  localparam int K_JAL = 5, K_JALR = 6, K_LUI = 7, K_ILL = 8;

  logic clk = 1'b0;
  logic rst_n, Zero, mem_ready;
  logic [6:0] op, funct7;
  logic [2:0] funct3;
  logic PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite, instr_done, illegal_op;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [3:0] ALUControl;
  logic [2:0] ImmSrc;
  ctl_t act;

  ctl_t exp_q[$];
  int   lat_q[$];
  int   tests = 0, fails = 0, cyc = 0, cyc_cnt = 0;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7(funct7),
    .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSrc(ImmSrc),
    .RegWrite(RegWrite), .instr_done(instr_done), .illegal_op(illegal_op)
  );

  assign act = {PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                ALUControl, ImmSrc, RegWrite, instr_done, illegal_op};

  always #5 clk = ~clk;

  function automatic logic rb();
    logic [31:0] r;
    r = $urandom;
    return r[0];
  endfunction

  // ALU operation named by the instruction's funct fields
  function automatic logic [3:0] ref_alu(input logic is_r, input logic [2:0] f3, input logic [6:0] f7);
    logic [3:0] tbl [8];
    tbl = '{4'b0000, 4'b1010, 4'b1000, 4'b1001, 4'b0101, 4'b0110, 4'b0011, 4'b0010};
    if (f3 == 3'b000 && is_r && f7 == 7'b0100000) return 4'b0001;
    if (f3 == 3'b101 && f7 == 7'b0100000) return 4'b0111;
    return tbl[f3];
  endfunction

  function automatic logic [6:0] op_of(input int k);
    case (k)
      K_R:     return 7'b0110011;
      K_I:     return 7'b0010011;
      K_LOAD:  return 7'b0000011;
      K_STORE: return 7'b0100011;
      K_BR:    return 7'b1100011;
      K_JAL:   return 7'b1101111;
      K_JALR:  return 7'b1100111;
      K_LUI:   return 7'b0110111;
      default: return 7'b1111111;
    endcase
  endfunction

  // cycles per instruction with no memory wait states
  function automatic int base_lat(input int k);
    case (k)
      K_LOAD, K_JAL, K_JALR: return 5;
      K_BR:                  return 3;
      K_ILL:                 return 2;
      default:               return 4;
    endcase
  endfunction

  function automatic ctl_t fetch_v(input logic mr);
    ctl_t e = '0;
    e.mrd = 1'b1; e.srcb = 2'b10; e.res = 2'b10; e.pcw = mr; e.irw = mr;
    return e;
  endfunction

  function automatic ctl_t decode_v(input logic ill);
    ctl_t e = '0;
    e.srca = 2'b01; e.srcb = 2'b01; e.imm = 3'b010; e.ill = ill; e.done = ill;
    return e;
  endfunction

  function automatic ctl_t wb_v();
    ctl_t e = '0;
    e.rw = 1'b1; e.done = 1'b1;
    return e;
  endfunction

  task automatic step(input ctl_t e, input logic mr, input logic z);
    mem_ready = mr;
    Zero      = z;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input int k, input logic [2:0] f3, input logic [6:0] f7,
                           input int fw, input int mw, input logic zb);
    ctl_t e;
    op = op_of(k); funct3 = f3; funct7 = f7;
    lat_q.push_back(base_lat(k) + fw + ((k == K_LOAD || k == K_STORE) ? mw : 0));
    for (int i = 0; i < fw; i++) step(fetch_v(1'b0), 1'b0, rb());
    step(fetch_v(1'b1), 1'b1, rb());
    step(decode_v(k == K_ILL), rb(), rb());
    case (k)
      K_LOAD, K_STORE: begin
        e = '0; e.srca = 2'b10; e.srcb = 2'b01; e.imm = (k == K_STORE) ? 3'b001 : 3'b000;
        step(e, rb(), rb());
        for (int i = 0; i <= mw; i++) begin
          e = '0; e.adr = 1'b1;
          if (k == K_LOAD) e.mrd = 1'b1;
          else begin e.mwr = 1'b1; e.done = (i == mw); end
          step(e, (i == mw), rb());
        end
        if (k == K_LOAD) begin
          e = '0; e.res = 2'b01; e.rw = 1'b1; e.done = 1'b1;
          step(e, rb(), rb());
        end
      end
      K_R, K_I, K_LUI: begin
        e = '0;
        e.srca = (k == K_LUI) ? 2'b11 : 2'b10;
        e.srcb = (k == K_R) ? 2'b00 : 2'b01;
        e.imm  = (k == K_LUI) ? 3'b011 : 3'b000;
        e.alu  = (k == K_LUI) ? 4'b0000 : ref_alu(k == K_R, f3, f7);
        step(e, rb(), rb());
        step(wb_v(), rb(), rb());
      end
      K_BR: begin
        e = '0; e.srca = 2'b10; e.alu = 4'b0001; e.done = 1'b1;
        e.pcw = (f3 == 3'b000 && zb) || (f3 == 3'b001 && !zb);
        step(e, rb(), zb);
      end
      K_JAL, K_JALR: begin
        e = '0; e.srcb = 2'b01;
        e.srca = (k == K_JAL) ? 2'b01 : 2'b10;
        e.imm  = (k == K_JAL) ? 3'b100 : 3'b000;
        step(e, rb(), rb());
        e = '0; e.srca = 2'b01; e.srcb = 2'b10; e.pcw = 1'b1;
        step(e, rb(), rb());
        step(wb_v(), rb(), rb());
      end
      default: ;
    endcase
  endtask

  // scoreboard monitor: per-cycle controls and per-instruction latency
  always @(negedge clk) begin
    ctl_t e;
    int   l;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (act !== e) begin
        fails++;
        $display("FAIL ctl cycle %0d op=%b f3=%b: got %h required %h", cyc, op, funct3, act, e);
      end
    end
    if (!rst_n) cyc_cnt = 0;
    else begin
      cyc_cnt++;
      if (instr_done === 1'b1) begin
        tests++;
        if (lat_q.size() == 0) begin
          fails++;
          $display("FAIL latency cycle %0d: got unexpected instr_done required none", cyc);
        end else begin
          l = lat_q.pop_front();
          if (cyc_cnt != l) begin
            fails++;
            $display("FAIL latency cycle %0d: got %0d required %0d", cyc, cyc_cnt, l);
          end
        end
        cyc_cnt = 0;
      end
    end
  end

  initial begin
    int k, fsel;
    logic [6:0] f7;
    rst_n = 1'b0; mem_ready = 1'b1; Zero = 1'b0; op = 7'd0; funct3 = 3'd0; funct7 = 7'd0;
    @(posedge clk);
    #1;
    step('0, 1'b1, 1'b0);
    step('0, 1'b1, 1'b0);
    rst_n = 1'b1;
    // directed cases
    run_instr(K_R, 3'b000, 7'b0000000, 0, 0, 1'b0);
    run_instr(K_R, 3'b000, 7'b0100000, 0, 0, 1'b0);
    run_instr(K_LOAD, 3'b010, 7'b0000000, 0, 3, 1'b0);
    run_instr(K_BR, 3'b000, 7'b0000000, 0, 0, 1'b1);
    run_instr(K_BR, 3'b001, 7'b0000000, 0, 0, 1'b1);
    run_instr(K_BR, 3'b100, 7'b0000000, 0, 0, 1'b1);
    run_instr(K_JALR, 3'b000, 7'b0000000, 0, 0, 1'b0);
    run_instr(K_JAL, 3'b000, 7'b0000000, 0, 0, 1'b0);
    run_instr(K_ILL, 3'b000, 7'b0000000, 0, 0, 1'b0);
    run_instr(K_I, 3'b000, 7'b0100000, 1, 0, 1'b0);
    run_instr(K_I, 3'b101, 7'b0100000, 0, 0, 1'b0);
    run_instr(K_LUI, 3'b000, 7'b0000000, 0, 0, 1'b0);
    run_instr(K_STORE, 3'b010, 7'b0000000, 2, 2, 1'b0);
    // store aborted by reset while waiting in the write phase
    op = 7'b0100011; funct3 = 3'b010; funct7 = 7'd0;
    step(fetch_v(1'b1), 1'b1, rb());
    step(decode_v(1'b0), rb(), rb());
    begin
      ctl_t e;
      e = '0; e.srca = 2'b10; e.srcb = 2'b01; e.imm = 3'b001;
      step(e, rb(), rb());
      e = '0; e.mwr = 1'b1; e.adr = 1'b1;
      step(e, 1'b0, rb());
    end
    rst_n = 1'b0;
    step('0, 1'b1, rb());
    rst_n = 1'b1;
    run_instr(K_R, 3'b111, 7'b0000000, 0, 0, 1'b0);
    // randomized instruction stream
    for (int n = 0; n < 200; n++) begin
      k    = $urandom_range(0, 8);
      fsel = $urandom_range(0, 3);
      case (fsel)
        0:       f7 = 7'b0000000;
        2:       f7 = 7'($urandom_range(0, 127));
        default: f7 = 7'b0100000;
      endcase
      run_instr(k, 3'($urandom_range(0, 7)), f7, $urandom_range(0, 2), $urandom_range(0, 3), rb());
    end
    @(negedge clk);
    #1;
    tests++;
    if (exp_q.size() != 0 || lat_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d/%0d pending required 0/0", exp_q.size(), lat_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
